// File: rtl/fc_neuron_mac_pkg.sv
// Shared types, defaults and the saturation helper for the FC neuron MAC.
package fc_pkg;

  localparam int unsigned FC_BUFFER_SIZE       = 120;
  localparam int unsigned FC_WORD_SIZE         = 16;
  localparam int unsigned FC_MEM_ADDRESS_WIDTH = 3;
  localparam int unsigned FC_FRAC_BITS         = 8;
  localparam int unsigned SAT_MAX_WIDTH        = 64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUF,
    MAC,
    DRAIN,
    DONE
  } fc_mac_state_t;

  // Clamp a sign-extended in_width-bit value into the signed out_width-bit range.
  function automatic logic signed [SAT_MAX_WIDTH-1:0] sat_signed(
    input logic signed [SAT_MAX_WIDTH-1:0] x,
    input int unsigned                     in_width,
    input int unsigned                     out_width
  );
    logic signed [SAT_MAX_WIDTH-1:0] hi;
    logic signed [SAT_MAX_WIDTH-1:0] lo;
    logic signed [SAT_MAX_WIDTH-1:0] res;
    hi  = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_width - 1));
    res = x;
    if (in_width > out_width) begin
      if (x > hi) begin
        res = hi;
      end else if (x < lo) begin
        res = lo;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fc_neuron_mac_if.sv
// Control, weight-memory and result bundle between a requester and the neuron MAC.
interface fc_neuron_mac_if #(
  parameter int unsigned BUFFER_SIZE       = fc_pkg::FC_BUFFER_SIZE,
  parameter int unsigned WORD_SIZE         = fc_pkg::FC_WORD_SIZE,
  parameter int unsigned MEM_ADDRESS_WIDTH = fc_pkg::FC_MEM_ADDRESS_WIDTH
);

  logic                                      i_start;
  logic [0:BUFFER_SIZE-1][WORD_SIZE-1:0]     i_buffer;
  logic                                      i_buffer_ready;
  logic [MEM_ADDRESS_WIDTH-1:0]              i_weight_address;
  logic [MEM_ADDRESS_WIDTH-1:0]              i_count;
  logic [WORD_SIZE-1:0]                      i_bias;
  logic [WORD_SIZE-1:0]                      i_mem_data;
  logic [MEM_ADDRESS_WIDTH-1:0]              o_mem_addr;
  logic [WORD_SIZE-1:0]                      o_result;
  logic                                      o_ready;
  logic                                      o_busy;

  modport master (
    output i_start, i_buffer, i_buffer_ready, i_weight_address, i_count, i_bias, i_mem_data,
    input  o_mem_addr, o_result, o_ready, o_busy
  );

  modport slave (
    input  i_start, i_buffer, i_buffer_ready, i_weight_address, i_count, i_bias, i_mem_data,
    output o_mem_addr, o_result, o_ready, o_busy
  );

endinterface

// File: rtl/fc_neuron_mac_datapath.sv
// Product register, accumulator and output saturator for one neuron evaluation.
module fc_mac_datapath
  import fc_pkg::*;
#(
  parameter int unsigned WORD_SIZE = FC_WORD_SIZE,
  parameter int unsigned FRAC_BITS = FC_FRAC_BITS,
  parameter int unsigned ACC_WIDTH = 2 * FC_WORD_SIZE + FC_MEM_ADDRESS_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        mac_en,
  input  logic                        drain,
  input  logic                        publish,
  input  logic signed [WORD_SIZE-1:0] act,
  input  logic signed [WORD_SIZE-1:0] wgt,
  input  logic signed [WORD_SIZE-1:0] bias,
  output logic        [WORD_SIZE-1:0] result
);

  localparam int unsigned PROD_W = 2 * WORD_SIZE;

  logic signed [PROD_W-1:0]        prod_q;
  logic signed [PROD_W-1:0]        prod_c;
  logic                            prod_valid_q;
  logic signed [ACC_WIDTH-1:0]     acc_q;
  logic signed [ACC_WIDTH-1:0]     bias_ext_c;
  logic signed [ACC_WIDTH-1:0]     shifted_c;
  logic signed [SAT_MAX_WIDTH-1:0] shifted_wide_c;
  logic signed [SAT_MAX_WIDTH-1:0] sat_wide_c;

  assign prod_c         = PROD_W'(act) * PROD_W'(wgt);
  assign bias_ext_c     = ACC_WIDTH'(bias) <<< FRAC_BITS;
  assign shifted_c      = acc_q >>> FRAC_BITS;
  assign shifted_wide_c = SAT_MAX_WIDTH'(shifted_c);
  assign sat_wide_c     = sat_signed(shifted_wide_c, ACC_WIDTH - FRAC_BITS, WORD_SIZE);

  // Pipelined multiply-accumulate: the product lands one cycle before it is summed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      acc_q        <= '0;
    end else if (load) begin
      prod_valid_q <= 1'b0;
      acc_q        <= bias_ext_c;
    end else if (mac_en) begin
      prod_q       <= prod_c;
      prod_valid_q <= 1'b1;
      if (prod_valid_q) begin
        acc_q <= acc_q + ACC_WIDTH'(prod_q);
      end
    end else if (drain) begin
      prod_valid_q <= 1'b0;
      acc_q        <= acc_q + ACC_WIDTH'(prod_q);
    end
  end

  // Rescaled, saturated result captured once per evaluation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result <= '0;
    end else if (publish) begin
      result <= WORD_SIZE'(sat_wide_c);
    end
  end

endmodule

// File: rtl/fc_neuron_mac.sv
// Fully-connected neuron: streams a weight row against the DMA buffer and emits one output.
module fc_neuron_mac
  import fc_pkg::*;
#(
  parameter int unsigned BUFFER_SIZE       = FC_BUFFER_SIZE,
  parameter int unsigned WORD_SIZE         = FC_WORD_SIZE,
  parameter int unsigned MEM_ADDRESS_WIDTH = FC_MEM_ADDRESS_WIDTH,
  parameter int unsigned FRAC_BITS         = FC_FRAC_BITS,
  parameter int unsigned ACC_WIDTH         = 2 * WORD_SIZE + MEM_ADDRESS_WIDTH + 1
) (
  input  logic            clk,
  input  logic            reset,
  fc_neuron_mac_if.slave  bus
);

  localparam logic [MEM_ADDRESS_WIDTH-1:0] AONE = MEM_ADDRESS_WIDTH'(1);

  fc_mac_state_t                state_q;
  fc_mac_state_t                state_d;
  logic [MEM_ADDRESS_WIDTH-1:0] base_q;
  logic [MEM_ADDRESS_WIDTH-1:0] cnt_q;
  logic [WORD_SIZE-1:0]         bias_q;
  logic [MEM_ADDRESS_WIDTH-1:0] idx_q;
  logic [MEM_ADDRESS_WIDTH-1:0] idx_d;
  logic [MEM_ADDRESS_WIDTH-1:0] addr_q;
  logic [MEM_ADDRESS_WIDTH-1:0] addr_d;
  logic                         ready_q;
  logic                         ready_d;
  logic                         busy_q;
  logic                         busy_d;
  logic                         accept_c;
  logic                         load_c;
  logic                         mac_c;
  logic                         drain_c;
  logic                         publish_c;

  assign accept_c = bus.i_start && ((state_q == IDLE) || (state_q == DONE));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept_c) state_d = WAIT_BUF;
      WAIT_BUF: if (bus.i_buffer_ready) state_d = (cnt_q == '0) ? DONE : MAC;
      MAC:      if (idx_q == cnt_q - AONE) state_d = DRAIN;
      DRAIN:    state_d = DONE;
      DONE:     if (accept_c) state_d = WAIT_BUF;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath strobes and next values for the registered outputs.
  always_comb begin
    load_c    = 1'b0;
    mac_c     = 1'b0;
    drain_c   = 1'b0;
    publish_c = 1'b0;
    ready_d   = ready_q;
    busy_d    = 1'b0;
    addr_d    = '0;
    idx_d     = idx_q;
    case (state_q)
      WAIT_BUF: begin
        load_c = bus.i_buffer_ready;
        idx_d  = '0;
      end
      MAC: begin
        mac_c = 1'b1;
        idx_d = idx_q + AONE;
      end
      DRAIN:   drain_c = 1'b1;
      DONE: begin
        publish_c = !ready_q && !accept_c;
        ready_d   = 1'b1;
      end
      default: ;
    endcase
    if (accept_c) begin
      ready_d = 1'b0;
    end
    if (state_d == MAC) begin
      addr_d = (state_q == MAC) ? addr_q + AONE : base_q;
    end
    busy_d = (state_d == WAIT_BUF) || (state_d == MAC) || (state_d == DRAIN);
  end

  // Request latch, MAC index and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q  <= '0;
      cnt_q   <= '0;
      bias_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (accept_c) begin
        base_q <= bus.i_weight_address;
        cnt_q  <= bus.i_count;
        bias_q <= bus.i_bias;
      end
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.o_mem_addr = addr_q;
  assign bus.o_ready    = ready_q;
  assign bus.o_busy     = busy_q;

  fc_mac_datapath #(
    .WORD_SIZE (WORD_SIZE),
    .FRAC_BITS (FRAC_BITS),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .load    (load_c),
    .mac_en  (mac_c),
    .drain   (drain_c),
    .publish (publish_c),
    .act     (bus.i_buffer[idx_q]),
    .wgt     (bus.i_mem_data),
    .bias    (bias_q),
    .result  (bus.o_result)
  );

endmodule

// File: doc/fc_neuron_mac.md
Name: fc_neuron_mac

Overview:
Downstream consumer of the DMA input buffer in the fully-connected datapath. Once the DMA reports its buffer ready, the block streams i_count weight words from weight memory and multiply-accumulates them against buffer entries 0..i_count-1. It adds a bias, rescales and saturates the sum, and presents one neuron output with a ready level. It uses the same combinational-read memory port style as the DMA: address out, data back in the same cycle.

Parameters:
BUFFER_SIZE, 120, number of WORD_SIZE entries in i_buffer; must be >= 2**MEM_ADDRESS_WIDTH.
WORD_SIZE, 16, signed fixed-point word width for inputs, weights, bias and result.
MEM_ADDRESS_WIDTH, 3, weight memory address width; also the width of i_count.
FRAC_BITS, 8, fractional bits of the WORD_SIZE format (Q(WORD_SIZE-FRAC_BITS).FRAC_BITS).
ACC_WIDTH, 2*WORD_SIZE+MEM_ADDRESS_WIDTH+1, signed accumulator width.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
i_start  in  1  request one neuron evaluation; sampled in IDLE or DONE only.
i_buffer  in  [0:BUFFER_SIZE-1][WORD_SIZE-1:0]  input activations from the DMA; held stable by the producer while o_busy=1.
i_buffer_ready  in  1  DMA ready flag; i_buffer is valid when this is high.
i_weight_address  in  MEM_ADDRESS_WIDTH  base address of the weight row.
i_count  in  MEM_ADDRESS_WIDTH  number of products to accumulate.
i_bias  in  WORD_SIZE  signed bias in the WORD_SIZE fixed-point format.
i_mem_data  in  WORD_SIZE  weight word at o_mem_addr, same cycle.
o_mem_addr  out  MEM_ADDRESS_WIDTH  weight memory address.
o_result  out  WORD_SIZE  saturated neuron output.
o_ready  out  1  o_result valid; level signal.
o_busy  out  1  high in WAIT_BUF, MAC and DRAIN.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; o_result=0, o_ready=0, o_busy=0, o_mem_addr=0; index, accumulator, product register and product-valid flag all cleared. Reset mid-operation abandons the evaluation; no partial result is shown.
- i_start, i_weight_address, i_count and i_bias are latched on the edge that accepts i_start.
- IDLE/DONE + i_start=1 -> WAIT_BUF: latch inputs; clear o_ready.
- i_start while o_busy=1 is ignored.
- WAIT_BUF:
  - i_buffer_ready=0: stay in WAIT_BUF.
  - i_buffer_ready=1 and count=0: go to DONE; o_result=i_bias.
  - i_buffer_ready=1 and count>0: go to MAC; idx=0; acc = sign-extended bias shifted left by FRAC_BITS.
- MAC, one product per cycle:
  - o_mem_addr = base+idx, modulo 2**MEM_ADDRESS_WIDTH (address wraps).
  - prod <= signed(i_buffer[idx]) * signed(i_mem_data) at full 2*WORD_SIZE precision; prod_valid<=1.
  - If prod_valid, acc <= acc + sign-extended prod.
  - idx increments each cycle; at idx==count-1, go to DRAIN.
- DRAIN: acc <= acc + prod (the last product); go to DONE.
- Entering DONE:
  - o_result <= sat(acc >>> FRAC_BITS), arithmetic shift.
  - sat() clamps to [-2**(WORD_SIZE-1), 2**(WORD_SIZE-1)-1].
  - o_ready <= 1; o_busy <= 0.
- DONE: o_result and o_ready hold until the next accepted i_start.
- o_mem_addr = 0 outside MAC.
- Latency with i_buffer_ready already high: o_ready rises count+3 rising edges after the edge that accepted i_start; for count=0, 2 edges.
- Accumulator never overflows at the default ACC_WIDTH; saturation applies only at the output.

Decomposition:
- Shared package fc_pkg holds:
  - state enum fc_mac_state_t {IDLE, WAIT_BUF, MAC, DRAIN, DONE};
  - a signed-saturate function parameterised by input and output widths;
  - FRAC_BITS default constant.
- One natural sub-module: fc_mac_datapath, containing the product register, the accumulator and the output saturator; the FSM stays in fc_neuron_mac.

Test Plan:
1. FRAC_BITS=0; buffer[0..3]={1,2,3,4}; mem[k]=k; addr=1, count=4, bias=5 -> o_mem_addr 1,2,3,4 on consecutive cycles; o_result=35; o_ready rises 7 edges after start.
2. FRAC_BITS=8; buffer[i]=0x0100 (1.0); mem[k]=k<<8; addr=6, count=4 -> addresses 6,7,0,1 (wrap); o_result=0x0E00 (14.0).
3. FRAC_BITS=0; all buffer and mem words 0x7FFF; count=4 -> o_result=0x7FFF. Buffer words 0x8000 against mem 0x7FFF -> o_result=0x8000.
4. count=0, bias=0xFF80 -> o_result=0xFF80; o_ready 2 edges after start; o_mem_addr stays 0.
5. i_buffer_ready held low 5 cycles after start -> o_busy=1, o_mem_addr=0 throughout; MAC begins on the edge after it rises; result matches test 1.
6. reset pulsed low at the 2nd MAC cycle -> all outputs 0 immediately (asynchronous). A restart with test-1 stimulus gives 35. A second i_start during MAC is ignored and the result is unchanged.
